// File: rtl/logic_accum.sv
// logic_accum: selectable bitwise operation unit with valid/ready handshakes.
// Pairwise mode computes In1 op In2 once per beat; reduce mode folds a
// multi-beat In1 stream into one result, force-closing at MAX_BEATS beats.
// Optional build macro LOGIC_ACCUM_PARITY_EN adds OutParity (XOR of OutData).
module logic_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             InLast,
    input  logic [2:0]       Op,
    input  logic             Mode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [CNT_W-1:0] OutBeats,
    output logic             OutOvf
`ifdef LOGIC_ACCUM_PARITY_EN
    ,
    output logic             OutParity
`endif
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic               ovf_q, ovf_d;
    logic               beat;
    logic [WIDTH-1:0]   fold;
    logic [CNT_W-1:0]   cnt_inc;

    // Non-inverting core of each op; pass (6-7) keeps the first operand.
    function automatic logic [WIDTH-1:0] base_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0, 3'd3: base_op = a & b;
            3'd1, 3'd4: base_op = a | b;
            3'd2, 3'd5: base_op = a ^ b;
            default:    base_op = a;
        endcase
    endfunction

    // NAND/NOR/XNOR are the base result inverted once at the end.
    function automatic logic [WIDTH-1:0] finish_op(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] v);
        finish_op = (op == 3'd3 || op == 3'd4 || op == 3'd5) ? ~v : v;
    endfunction

    // Ready whenever no result is stuck waiting; held low through reset.
    always_comb begin
        InReady = ~Rst & ((state_q != StHold) | OutReady);
        beat    = InValid & InReady;
        fold    = base_op(op_q, acc_q, In1);
        cnt_inc = cnt_q + CNT_W'(1);
    end

    // Next-state logic: HOLD with retire behaves exactly like IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        beats_d = beats_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (state_q == StHold && OutReady && !beat) begin
                    state_d = StIdle;
                end
                if (beat) begin
                    op_d = Op;
                    if (!Mode) begin
                        data_d  = finish_op(Op, base_op(Op, In1, In2));
                        beats_d = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = StHold;
                    end else begin
                        acc_d = In1;
                        cnt_d = CNT_W'(1);
                        if (InLast) begin
                            data_d  = finish_op(Op, In1);
                            beats_d = CNT_W'(1);
                            ovf_d   = 1'b0;
                            state_d = StHold;
                        end else begin
                            state_d = StAcc;
                        end
                    end
                end
            end
            StAcc: begin
                if (beat) begin
                    acc_d = fold;
                    cnt_d = cnt_inc;
                    if (InLast || cnt_inc == CNT_W'(MAX_BEATS)) begin
                        data_d  = finish_op(op_q, fold);
                        beats_d = cnt_inc;
                        ovf_d   = ~InLast;
                        state_d = StHold;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers, cleared asynchronously.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OutValid = (state_q == StHold);
    assign OutData  = data_q;
    assign OutBeats = beats_q;
    assign OutOvf   = ovf_q;

`ifdef LOGIC_ACCUM_PARITY_EN
    logic parity_q;

    // Parity tracks the result register so it is stable alongside it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign OutParity = parity_q;
`endif

endmodule

// File: tb/tb_logic_accum.sv
// Scoreboard bench for logic_accum (WIDTH=8, MAX_BEATS=4).
`timescale 1ns/1ps
module tb_logic_accum;

    localparam int W  = 8;
    localparam int MB = 4;
    localparam int CW = $clog2(MB + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          in_last;
    logic [2:0]    op;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_beats;
    logic          out_ovf;
`ifdef LOGIC_ACCUM_PARITY_EN
    logic          out_parity;
`endif

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] b;
        logic          o;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic_accum #(
        .WIDTH    (W),
        .MAX_BEATS(MB)
    ) dut (
        .Clk      (clk),
        .Rst      (rst),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .In1      (in1),
        .In2      (in2),
        .InLast   (in_last),
        .Op       (op),
        .Mode     (mode),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .OutData  (out_data),
        .OutBeats (out_beats),
        .OutOvf   (out_ovf)
`ifdef LOGIC_ACCUM_PARITY_EN
        ,
        .OutParity(out_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent truth table for a pairwise result.
    function automatic logic [W-1:0] ref_pair(input logic [2:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (o)
            3'd0:    ref_pair = a & b;
            3'd1:    ref_pair = a | b;
            3'd2:    ref_pair = a ^ b;
            3'd3:    ref_pair = ~(a & b);
            3'd4:    ref_pair = ~(a | b);
            3'd5:    ref_pair = ~(a ^ b);
            default: ref_pair = a;
        endcase
    endfunction

    task automatic push(input logic [W-1:0] d, input logic [CW-1:0] b, input logic o);
        exp_t e;
        e.d = d;
        e.b = b;
        e.o = o;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic m, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic last);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        mode     = m;
        op       = o;
        in1      = a;
        in2      = b;
        in_last  = last;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every result transfer and checks held outputs stay frozen.
    initial begin
        exp_t          e;
        logic          stalled;
        logic [W-1:0]  held_d;
        logic [CW-1:0] held_b;
        stalled = 1'b0;
        held_d  = '0;
        held_b  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(held_d));
                    check("hold_beats", 32'(out_beats), 32'(held_b));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 32'(out_data), 32'(e.d));
                        check("out_beats", 32'(out_beats), 32'(e.b));
                        check("out_ovf", 32'(out_ovf), 32'(e.o));
`ifdef LOGIC_ACCUM_PARITY_EN
                        check("out_parity", 32'(out_parity), 32'(^e.d));
`endif
                    end
                end
                stalled = out_valid && !out_ready;
                held_d  = out_data;
                held_b  = out_beats;
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        in_last   = 1'b0;
        op        = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_beats", 32'(out_beats), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", 32'(in_ready), 32'd1);

        // Pairwise AND, one-cycle latency.
        push(8'h30, 1, 1'b0);
        send(1'b0, 3'd0, 8'hF0, 8'h3C, 1'b0);
        check("pair_lat_valid", 32'(out_valid), 32'd1);
        check("pair_lat_data", 32'(out_data), 32'h30);

        // Every op back to back in pairwise mode.
        for (int i = 0; i < 8; i++) begin
            push(ref_pair(3'(i), 8'hCA, 8'h5C), 1, 1'b0);
            send(1'b0, 3'(i), 8'hCA, 8'h5C, 1'b0);
        end

        // Reduce XOR; Op/Mode changes mid-packet must be ignored.
        push(8'h07, 3, 1'b0);
        send(1'b1, 3'd2, 8'h01, 8'h00, 1'b0);
        check("red_ready1", 32'(in_ready), 32'd1);
        send(1'b0, 3'd0, 8'h02, 8'hFF, 1'b0);
        check("red_ready2", 32'(in_ready), 32'd1);
        send(1'b1, 3'd5, 8'h04, 8'h00, 1'b1);
        check("red_lat_valid", 32'(out_valid), 32'd1);

        // Reduce NAND two beats, then single-beat NOR.
        push(8'hF0, 2, 1'b0);
        send(1'b1, 3'd3, 8'hFF, 8'h00, 1'b0);
        send(1'b1, 3'd3, 8'h0F, 8'h00, 1'b1);
        push(8'h5A, 1, 1'b0);
        send(1'b1, 3'd4, 8'hA5, 8'h00, 1'b1);

        // Forced close at MAX_BEATS, next beat opens a new packet.
        push(8'h0F, 4, 1'b1);
        push(8'h10, 1, 1'b0);
        send(1'b1, 3'd1, 8'h01, 8'h00, 1'b0);
        send(1'b1, 3'd1, 8'h02, 8'h00, 1'b0);
        send(1'b1, 3'd1, 8'h04, 8'h00, 1'b0);
        send(1'b1, 3'd1, 8'h08, 8'h00, 1'b0);
        check("ovf_close_valid", 32'(out_valid), 32'd1);
        send(1'b1, 3'd1, 8'h10, 8'h00, 1'b1);
        drain();

        // Backpressure: stall three cycles, then full throughput.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    a = W'($urandom);
                    b = W'($urandom);
                    push(a ^ b, 1, 1'b0);
                    send(1'b0, 3'd2, a, b, 1'b0);
                end
            end
            begin
                for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
                for (int c = 0; c < 3; c++) begin
                    check("stall_ready", 32'(in_ready), 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("thruput_valid", 32'(out_valid), 32'd1);
                end
            end
        join
        drain();

        // Asynchronous reset mid-packet discards partial state.
        send(1'b1, 3'd0, 8'h11, 8'h00, 1'b0);
        send(1'b1, 3'd0, 8'h22, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_beats", 32'(out_beats), 32'd0);
        check("arst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(8'h3C, 1, 1'b0);
        send(1'b1, 3'd0, 8'h3C, 8'h00, 1'b1);
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_accum.md
Name: logic_accum

Overview:
- Parametrised successor to the team's 2-input gate primitives.
- Six selectable bitwise operations on WIDTH-bit operands, with valid/ready handshakes and a registered result.
- Two modes:
  - Pairwise: In1 op In2, one result per beat.
  - Reduce: folds a multi-beat stream of In1 words into a single result.
- Sits between operand producers and the datapath register file in DSD lab designs.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- MAX_BEATS, 16, maximum beats per reduce packet before forced completion (>=2).
- CNT_W, $clog2(MAX_BEATS+1), beat counter width (derived, not overridden).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous active-high reset.
- InValid  input  1  operand beat valid.
- InReady  output  1  block accepts a beat this cycle.
- In1  input  WIDTH  operand A; the stream word in reduce mode.
- In2  input  WIDTH  operand B; ignored in reduce mode.
- InLast  input  1  last beat of a reduce packet; ignored in pairwise mode.
- Op  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 pass In1.
- Mode  input  1  0 pairwise, 1 reduce.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts the result.
- OutData  output  WIDTH  result.
- OutBeats  output  CNT_W  beats folded into OutData (1 in pairwise mode).
- OutOvf  output  1  reduce packet force-closed at MAX_BEATS.

Behaviour:
- Reset: asynchronous, active-high; Clk is the only clock.
  - While Rst=1: state IDLE, accumulator=0, beat count=0, OutValid=0, OutData=0, OutBeats=0, OutOvf=0.
  - InReady=0 while Rst=1.
- Beat transfer: InValid & InReady at a rising edge. Result transfer: OutValid & OutReady.
- InReady = (state != HOLD) | OutReady. Combinational from state and OutReady only; never from InValid.
- Op and Mode are latched on the first beat of a packet (every beat in pairwise mode). Changes mid-packet are ignored.
- State IDLE: no partial result, output empty.
  - Pairwise beat: OutData <= In1 op In2, OutBeats <= 1, OutOvf <= 0 -> HOLD.
  - Reduce beat: accumulator <= In1, count <= 1. Goes to HOLD if InLast, else ACC.
- State ACC: partial reduction in progress. OutValid=0.
  - Each beat: accumulator <= accumulator base_op In1, count++. Base ops: AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR; pass keeps the first word.
  - If InLast, or count reaches MAX_BEATS on this beat: goes to HOLD.
  - On entering HOLD: OutData <= accumulator result, inverted for NAND/NOR/XNOR. OutOvf <= 1 only if the packet closed on count==MAX_BEATS without InLast.
  - A single-beat reduce packet returns In1, inverted for the inverting ops.
- State HOLD: OutValid=1; OutData, OutBeats and OutOvf held stable until transfer.
  - OutReady=0: InReady=0, no state change.
  - OutReady=1 with no beat: goes to IDLE, and OutValid deasserts the next cycle.
  - OutReady=1 with a simultaneous beat: result retired and the new beat processed as from IDLE in the same edge. Full throughput: one pairwise result per cycle.
- Latency: pairwise result valid 1 cycle after the accepting edge. Reduce result valid 1 cycle after the last beat.
- Overflow: after a forced close at MAX_BEATS, the next beat starts a new packet even if it carries InLast.
- Reset mid-packet: partial accumulation and any held result are discarded, with no output pulse.

Optional Feature:
- Macro: LOGIC_ACCUM_PARITY_EN.
- Defined: adds output port OutParity (1 bit) = XOR-reduction of OutData. It is registered with OutData, reset to 0 and held stable in HOLD.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- WIDTH=8, Mode=0, Op=0, In1=0xF0, In2=0x3C, single beat -> next cycle OutValid=1, OutData=0x30, OutBeats=1, OutOvf=0.
- Mode=1, Op=2, beats 0x01, 0x02, 0x04 with InLast on the third -> OutData=0x07, OutBeats=3, OutOvf=0; InReady=1 throughout the packet.
- Mode=1, Op=3, beats 0xFF then 0x0F with InLast -> OutData=0xF0, OutBeats=2; single beat 0xA5 with Op=4 -> OutData=0x5A, OutBeats=1.
- Pairwise stream of 4 XOR beats with OutReady held 0 for 3 cycles after the first result -> InReady=0 and OutData frozen while stalled; after release, one result per cycle in order, none lost or duplicated.
- MAX_BEATS=4, Mode=1, Op=1, beats 0x01, 0x02, 0x04, 0x08, 0x10 with no InLast until the fifth -> first result 0x0F, OutBeats=4, OutOvf=1; second result 0x10, OutBeats=1, OutOvf=0.
- Rst pulsed asynchronously after 2 beats of a reduce packet -> all outputs 0 immediately; post-reset packet 0x3C with InLast, Op=0 -> OutData=0x3C, OutBeats=1.
